// File: rtl/mul_result_unloader.sv
// ============================================================================
// Module   : mul_result_unloader
// Captures the compressor result columns and returns them LSB-first over a
// 1-bit valid/ready link, folding each accepted word into a 16-bit MISR.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mul_result_unloader #(
    parameter int WIDTH = 45,
    parameter int SIG_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture,
    input  logic [WIDTH-1:0] dst,
    input  logic             ser_ready,
    input  logic             clear_ovr,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             busy,
    output logic             overrun,
    output logic [15:0]      frames,
    output logic [SIG_W-1:0] sig
);

    localparam int c_IDX_W  = $clog2(WIDTH);
    localparam int c_NCHUNK = (WIDTH + SIG_W - 1) / SIG_W;
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(WIDTH - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t             r_state;
    logic [WIDTH-1:0]   r_hold;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_ser_out;
    logic               r_ser_valid;
    logic               r_ser_last;
    logic               r_overrun;
    logic [15:0]        r_frames;
    logic [SIG_W-1:0]   r_sig;

    logic [c_NCHUNK*SIG_W-1:0] w_dst_pad;
    logic [SIG_W-1:0]          w_fold;
    logic                      w_fb;
    logic [SIG_W-1:0]          w_sig_next;
    logic                      w_xfer;
    logic                      w_at_last;
    logic                      w_accept;
    logic                      w_drop;
    logic [c_IDX_W-1:0]        w_idx_inc;

    // Zero-pad the word to whole chunks, then XOR the chunks together.
    always_comb begin
        w_dst_pad            = '0;
        w_dst_pad[WIDTH-1:0] = dst;
        w_fold               = '0;
        for (int k = 0; k < c_NCHUNK; k++) begin
            w_fold = w_fold ^ w_dst_pad[k*SIG_W +: SIG_W];
        end
    end

    assign w_fb       = r_sig[15] ^ r_sig[14] ^ r_sig[12] ^ r_sig[3];
    assign w_sig_next = {r_sig[SIG_W-2:0], w_fb} ^ w_fold;

    assign w_xfer    = (r_state == ST_SHIFT) && ser_ready;
    assign w_at_last = (r_idx == c_LAST_IDX);
    // A new word is only taken when nothing is held, or on the beat that frees the holder.
    assign w_accept  = capture && ((r_state == ST_IDLE) || (w_xfer && w_at_last));
    assign w_drop    = capture && !w_accept;
    assign w_idx_inc = r_idx + c_IDX_ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_hold      <= '0;
            r_idx       <= '0;
            r_ser_out   <= 1'b0;
            r_ser_valid <= 1'b0;
            r_ser_last  <= 1'b0;
            r_overrun   <= 1'b0;
            r_frames    <= 16'd0;
            r_sig       <= '0;
        end else begin
            if (w_accept) begin
                r_state     <= ST_SHIFT;
                r_hold      <= dst;
                r_idx       <= '0;
                r_ser_out   <= dst[0];
                r_ser_valid <= 1'b1;
                r_ser_last  <= 1'b0;
                r_frames    <= r_frames + 16'd1;
                r_sig       <= w_sig_next;
            end else if (w_xfer) begin
                if (w_at_last) begin
                    r_state     <= ST_IDLE;
                    r_ser_out   <= 1'b0;
                    r_ser_valid <= 1'b0;
                    r_ser_last  <= 1'b0;
                end else begin
                    r_idx      <= w_idx_inc;
                    r_ser_out  <= r_hold[w_idx_inc];
                    r_ser_last <= (w_idx_inc == c_LAST_IDX);
                end
            end

            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clear_ovr) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign ser_out   = r_ser_out;
    assign ser_valid = r_ser_valid;
    assign ser_last  = r_ser_last;
    assign busy      = r_ser_valid;
    assign overrun   = r_overrun;
    assign frames    = r_frames;
    assign sig       = r_sig;

endmodule

`default_nettype wire

// File: tb/tb_mul_result_unloader.sv
// ============================================================================
// Module   : tb_mul_result_unloader
// Self-checking bench for mul_result_unloader against a queue-based model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_mul_result_unloader;

    localparam int W = 45;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          capture = 1'b0;
    logic [W-1:0]  dst = '0;
    logic          ser_ready = 1'b0;
    logic          clear_ovr = 1'b0;
    logic          ser_out;
    logic          ser_valid;
    logic          ser_last;
    logic          busy;
    logic          overrun;
    logic [15:0]   frames;
    logic [15:0]   sig;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] exp_frames = 16'd0;
    logic [15:0] exp_sig    = 16'd0;

    mul_result_unloader #(.WIDTH(W), .SIG_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .capture   (capture),
        .dst       (dst),
        .ser_ready (ser_ready),
        .clear_ovr (clear_ovr),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_last  (ser_last),
        .busy      (busy),
        .overrun   (overrun),
        .frames    (frames),
        .sig       (sig)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] sig_step(input logic [15:0] s, input logic [W-1:0] d);
        logic [63:0] x;
        logic        fb;
        x  = 64'(d);
        fb = s[15] ^ s[14] ^ s[12] ^ s[3];
        return {s[14:0], fb} ^ x[15:0] ^ x[31:16] ^ x[47:32] ^ x[63:48];
    endfunction

    function automatic logic [W-1:0] rand_word();
        return W'({$urandom, $urandom});
    endfunction

    function automatic logic bit_of(input logic [W-1:0] d, input int n);
        return logic'((64'(d) >> n) & 64'd1);
    endfunction

    task automatic do_reset();
        rst = 1'b1; capture = 1'b0; ser_ready = 1'b0; clear_ovr = 1'b0; dst = '0;
        tick();
        tick();
        rst = 1'b0;
        exp_frames = 16'd0;
        exp_sig    = 16'd0;
    endtask

    // Capture from idle and advance the model's frame count and signature.
    task automatic capture_word(input logic [W-1:0] d);
        capture = 1'b1;
        dst     = d;
        tick();
        capture = 1'b0;
        exp_frames = exp_frames + 16'd1;
        exp_sig    = sig_step(exp_sig, d);
    endtask

    task automatic drain();
        ser_ready = 1'b1;
        repeat (W) tick();
    endtask

    task automatic test_reset();
        do_reset();
        repeat (10) tick();
        n_total++;
        if ({ser_valid, busy, ser_out, ser_last, overrun} !== 5'b0) begin
            $display("FAIL reset_flags: got %b, want 00000", {ser_valid, busy, ser_out, ser_last, overrun});
        end else n_pass++;
        n_total++;
        if (sig !== 16'h0000 || frames !== 16'h0000) begin
            $display("FAIL reset_counters: sig=%h frames=%h, want 0000/0000", sig, frames);
        end else n_pass++;
    endtask

    task automatic test_single();
        logic eb;
        ser_ready = 1'b1;
        capture_word(W'(1));
        for (int b = 1; b <= W; b++) begin
            eb = (b == 1);
            n_total++;
            if (ser_valid !== 1'b1 || ser_out !== eb || ser_last !== (b == W)) begin
                $display("FAIL single_beat%0d: v/d/l=%b%b%b, want 1%b%b", b, ser_valid, ser_out, ser_last, eb, (b == W));
            end else n_pass++;
            tick();
        end
        n_total++;
        if (busy !== 1'b0 || ser_valid !== 1'b0) begin
            $display("FAIL single_done: busy=%b valid=%b, want 0/0", busy, ser_valid);
        end else n_pass++;
        n_total++;
        if (sig !== 16'h0001 || frames !== 16'd1) begin
            $display("FAIL single_sig: sig=%h frames=%0d, want 0001/1", sig, frames);
        end else n_pass++;
    endtask

    task automatic test_chain();
        capture_word('0);
        drain();
        n_total++;
        if (sig !== 16'h0002) $display("FAIL chain_sig2: sig=%h, want 0002", sig);
        else n_pass++;
        capture_word(W'(64'h1_0000_0000));
        drain();
        n_total++;
        if (sig !== 16'h0005 || frames !== 16'd3) begin
            $display("FAIL chain_sig5: sig=%h frames=%0d, want 0005/3", sig, frames);
        end else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] d;
        logic         pv, pd, pl;
        int           nx;
        int           bad;
        d = W'(64'h1555_5555_5555);
        ser_ready = 1'b0;
        capture_word(d);
        nx  = 0;
        bad = 0;
        for (int k = 0; k < 4 * W && nx < W; k++) begin
            ser_ready = (k % 2 == 0);
            pv = ser_valid; pd = ser_out; pl = ser_last;
            if (ser_ready && pv) begin
                n_total++;
                if (pd !== bit_of(d, nx) || pl !== (nx == W - 1)) begin
                    $display("FAIL bp_bit%0d: data/last=%b%b, want %b%b", nx, pd, pl, bit_of(d, nx), (nx == W - 1));
                end else n_pass++;
                nx++;
            end
            tick();
            if (!ser_ready && {ser_valid, ser_out, ser_last} !== {pv, pd, pl}) bad++;
        end
        n_total++;
        if (bad != 0 || nx != W) begin
            $display("FAIL bp_stall: unstable stalls=%0d transfers=%0d, want 0/%0d", bad, nx, W);
        end else n_pass++;
        n_total++;
        if (sig !== exp_sig || frames !== exp_frames || busy !== 1'b0) begin
            $display("FAIL bp_end: sig=%h frames=%0d busy=%b, want %h/%0d/0", sig, frames, busy, exp_sig, exp_frames);
        end else n_pass++;
    endtask

    task automatic test_overrun();
        logic [W-1:0] a;
        int           errs;
        a = rand_word();
        ser_ready = 1'b1;
        capture_word(a);
        errs = 0;
        for (int b = 1; b <= W; b++) begin
            if (ser_valid !== 1'b1 || ser_out !== bit_of(a, b - 1)) errs++;
            capture   = (b == 10) || (b == 20);
            dst       = capture ? ~a : a;
            clear_ovr = (b == 15) || (b == 20);
            tick();
            capture = 1'b0; clear_ovr = 1'b0;
            if (b == 10) begin
                n_total++;
                if (overrun !== 1'b1 || frames !== exp_frames || sig !== exp_sig) begin
                    $display("FAIL ovr_set: ovr=%b frames=%0d sig=%h, want 1/%0d/%h", overrun, frames, sig, exp_frames, exp_sig);
                end else n_pass++;
            end
            if (b == 15) begin
                n_total++;
                if (overrun !== 1'b0) $display("FAIL ovr_clear: ovr=%b, want 0", overrun);
                else n_pass++;
            end
            if (b == 20) begin
                n_total++;
                if (overrun !== 1'b1) $display("FAIL ovr_set_wins: ovr=%b, want 1", overrun);
                else n_pass++;
            end
        end
        n_total++;
        if (errs != 0 || busy !== 1'b0) begin
            $display("FAIL ovr_stream: bit errors=%0d busy=%b, want 0/0", errs, busy);
        end else n_pass++;
        clear_ovr = 1'b1;
        tick();
        clear_ovr = 1'b0;
    endtask

    task automatic test_back_to_back_reset();
        logic [W-1:0] a, bw, c;
        a  = rand_word();
        bw = rand_word();
        ser_ready = 1'b1;
        capture_word(a);
        repeat (W - 1) tick();
        n_total++;
        if (ser_last !== 1'b1) $display("FAIL b2b_last: ser_last=%b, want 1", ser_last);
        else n_pass++;
        capture_word(bw);
        n_total++;
        if (ser_valid !== 1'b1 || ser_out !== bw[0] || ser_last !== 1'b0 || frames !== exp_frames || sig !== exp_sig) begin
            $display("FAIL b2b_next: v/d/l=%b%b%b frames=%0d sig=%h, want 1%b0/%0d/%h", ser_valid, ser_out, ser_last, frames, sig, bw[0], exp_frames, exp_sig);
        end else n_pass++;
        repeat (19) tick();
        n_total++;
        if (ser_out !== bw[19]) $display("FAIL b2b_beat20: data=%b, want %b", ser_out, bw[19]);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if ({ser_out, ser_valid, ser_last, busy, overrun} !== 5'b0 || frames !== 16'd0 || sig !== 16'd0) begin
            $display("FAIL async_rst: flags=%b frames=%0d sig=%h, want 00000/0/0000", {ser_out, ser_valid, ser_last, busy, overrun}, frames, sig);
        end else n_pass++;
        tick();
        rst = 1'b0;
        exp_frames = 16'd0;
        exp_sig    = 16'd0;
        c = rand_word();
        capture_word(c);
        n_total++;
        if (frames !== 16'd1 || sig !== exp_sig || ser_out !== c[0]) begin
            $display("FAIL post_rst: frames=%0d sig=%h data=%b, want 1/%h/%b", frames, sig, ser_out, exp_sig, c[0]);
        end else n_pass++;
        drain();
    endtask

    // Random traffic against a model that holds the pending word as a bit queue.
    task automatic test_random();
        bit           q[$];
        logic         m_ovr;
        logic         cap, rdy, clr, xfer, acc;
        logic [W-1:0] d;
        do_reset();
        m_ovr = 1'b0;
        for (int k = 0; k < 600; k++) begin
            n_total++;
            if (ser_valid !== (q.size() != 0) || (q.size() != 0 && (ser_out !== q[0] || ser_last !== (q.size() == 1)))
                || frames !== exp_frames || sig !== exp_sig || overrun !== m_ovr) begin
                $display("FAIL rand_cyc%0d: v/d/l=%b%b%b ovr=%b frames=%0d sig=%h, want v=%b ovr=%b frames=%0d sig=%h",
                         k, ser_valid, ser_out, ser_last, overrun, frames, sig, (q.size() != 0), m_ovr, exp_frames, exp_sig);
            end else n_pass++;
            cap = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 14) == 0);
            d   = rand_word();
            capture = cap; ser_ready = rdy; clear_ovr = clr; dst = d;
            xfer = (q.size() != 0) && rdy;
            acc  = cap && ((q.size() == 0) || (xfer && q.size() == 1));
            if (xfer) void'(q.pop_front());
            if (acc) begin
                for (int i = 0; i < W; i++) q.push_back(bit_of(d, i));
                exp_frames = exp_frames + 16'd1;
                exp_sig    = sig_step(exp_sig, d);
            end
            if (cap && !acc) m_ovr = 1'b1;
            else if (clr) m_ovr = 1'b0;
            tick();
        end
        capture = 1'b0; clear_ovr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_chain();
        test_backpressure();
        test_overrun();
        test_back_to_back_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
